// File: rtl/wide_add_seq.sv
// Sequential 64-bit add/subtract built on an external shared 32-bit adder.
// The low half is computed first, then the high half with the chained carry.
module wide_add_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] x_q, x_d;
    logic [63:0] yeff_q, yeff_d;
    logic        cin0_q, cin0_d;
    logic        chain_q, chain_d;
    logic [63:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic        add_cin_q, add_cin_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        yeff_d   = yeff_q;
        cin0_d   = cin0_q;
        chain_d  = chain_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLo;
                    x_d     = x;
                    yeff_d  = op_sub ? ~y : y;
                    cin0_d  = op_sub;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLo: begin
                if (cnt_q == 4'd0) begin
                    result_d[31:0] = add_sum;
                    chain_d        = add_cout;
                    state_d        = StHi;
                    cnt_d          = CntLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHi: begin
                if (cnt_q == 4'd0) begin
                    result_d[63:32] = add_sum;
                    carry_d         = add_cout;
                    ovf_d           = (x_q[63] == yeff_q[63]) & (add_sum[31] != x_q[63]);
                    state_d         = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        busy_d    = (state_d == StLo) || (state_d == StHi);
        done_d    = (state_d == StDone);
        add_a_d   = 32'd0;
        add_b_d   = 32'd0;
        add_cin_d = 1'b0;
        case (state_d)
            StLo: begin
                add_a_d   = x_d[31:0];
                add_b_d   = yeff_d[31:0];
                add_cin_d = cin0_d;
            end
            StHi: begin
                add_a_d   = x_d[63:32];
                add_b_d   = yeff_d[63:32];
                add_cin_d = chain_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            x_q       <= 64'd0;
            yeff_q    <= 64'd0;
            cin0_q    <= 1'b0;
            chain_q   <= 1'b0;
            result_q  <= 64'd0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            add_a_q   <= 32'd0;
            add_b_q   <= 32'd0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            yeff_q    <= yeff_d;
            cin0_q    <= cin0_d;
            chain_q   <= chain_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_wide_add_seq;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned LAT    = 2 * SETTLE + 1;

    logic        clk = 1'b0;
    logic        rst, start, op_sub;
    logic [63:0] x, y;
    logic        busy, done, carry_out, overflow, add_cin, add_cout;
    logic [63:0] result;
    logic [31:0] add_a, add_b, add_sum;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Shared carry-lookahead adder stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    wide_add_seq #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {carry, overflow, result[63:0]} from true unsigned/signed arithmetic.
    function automatic logic [65:0] ref_op(input logic sub, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [64:0]        u;
        logic signed [64:0] s;
        logic               c;
        if (sub) begin
            u = {1'b0, a} - {1'b0, b};
            s = $signed({a[63], a}) - $signed({b[63], b});
            c = (a >= b);
        end else begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[63], a}) + $signed({b[63], b});
            c = u[64];
        end
        return {c, s[64] ^ s[63], u[63:0]};
    endfunction

    // Issue one operation from idle and wait (bounded) for done.
    // inject: pulse start with different operands while in LO.
    task automatic run_op(input string tag, input logic sub, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input logic exp_c, input logic exp_v, input logic inject,
                          output logic cin_hi);
        int n;
        @(negedge clk);
        start = 1'b1; op_sub = sub; x = a; y = b;
        @(negedge clk);
        start = 1'b0; op_sub = ~sub; x = {$urandom, $urandom}; y = {$urandom, $urandom};
        n = 1;
        cin_hi = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            if (n == SETTLE + 1) cin_hi = add_cin;
            if (inject && n == 2) begin
                start = 1'b1; op_sub = 1'b1; x = {$urandom, $urandom}; y = 64'd12345;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_carry"}, 64'(carry_out), 64'(exp_c));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_v));
        @(negedge clk);
        check({tag, "_hold"}, {done, busy, carry_out, overflow, result},
              {2'b00, exp_c, exp_v, exp_res});
    endtask

    initial begin
        logic        cin_hi;
        logic [65:0] m;
        logic [63:0] ra, rb;
        logic        rs, saw_done;
        logic [63:0] qa[$], qb[$];
        logic        qs[$];

        rst = 1'b1; start = 1'b1; op_sub = 1'b0; x = '1; y = '1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, carry_out, overflow, add_cin, 32'd0},
              {5'd0, 32'd0});
        check("reset_result", result, 64'd0);
        check("reset_adder", {add_a, add_b}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, done}, 64'd0);

        run_op("add_lo_carry", 1'b0, 64'h00000000_FFFFFFFF, 64'h1,
               64'h00000001_00000000, 1'b0, 1'b0, 1'b0, cin_hi);
        check("add_lo_carry_cin_hi", 64'(cin_hi), 64'd1);
        run_op("sub_neg", 1'b1, 64'h5, 64'h7, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0, cin_hi);
        run_op("add_ovf", 1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1,
               64'h80000000_00000000, 1'b0, 1'b1, 1'b0, cin_hi);
        run_op("add_wrap", 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b0, cin_hi);

        // start pulsed during LO is ignored
        run_op("start_in_lo", 1'b0, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321,
               64'h22222222_22222211, 1'b0, 1'b0, 1'b1, cin_hi);
        check("ignored_start_idle", {busy, done}, 64'd0);

        // rst during HI aborts with no done pulse
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; x = 64'hFFFF; y = 64'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("abort_in_hi_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {busy, done, carry_out, overflow, add_cin}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_adder", {add_a, add_b}, 64'd0);
        saw_done = 1'b0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        // start held high: back-to-back ops every LAT cycles
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom);
            if (i == 3) rb = ra;
            op_sub = rs; x = ra; y = rb;
            qa.push_back(ra); qb.push_back(rb); qs.push_back(rs);
            for (int k = 1; k < int'(LAT); k++) begin
                @(negedge clk);
                if (k == 1) begin
                    x = {$urandom, $urandom}; y = {$urandom, $urandom}; op_sub = ~rs;
                end
                check($sformatf("b2b%0d_nodone_c%0d", i, k), {busy, done}, 64'b10);
            end
            @(negedge clk);
            m = ref_op(qs.pop_front(), qa.pop_front(), qb.pop_front());
            check($sformatf("b2b%0d_done", i), 64'(done), 64'd1);
            check($sformatf("b2b%0d_result", i), result, m[63:0]);
            check($sformatf("b2b%0d_flags", i), {carry_out, overflow}, m[65:64]);
        end
        start = 1'b0;
        @(negedge clk);

        // isolated random operations, with biased corner operands
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom);
            case (i % 6)
                0: ra[63] = rb[63];
                1: rb = 64'h8000_0000_0000_0000;
                2: ra[31:0] = 32'hFFFF_FFFF;
                default: ;
            endcase
            m = ref_op(rs, ra, rb);
            run_op($sformatf("rand%0d", i), rs, ra, rb, m[63:0], m[65], m[64], 1'b0, cin_hi);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
- REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of cycles adder inputs are held before the adder result is sampled; the legal range is 1..15.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-004 The block SHALL have port start, input, 1 bit: operation request.
- REQ-005 The block SHALL have port op_sub, input, 1 bit: 0 selects x+y, 1 selects x-y; sampled with start.
- REQ-006 The block SHALL have ports x and y, input, 64 bits each: operands, sampled with start.
- REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
- REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
- REQ-009 The block SHALL have port result, output, 64 bits: the sum or difference.
- REQ-010 The block SHALL have ports carry_out and overflow, output, 1 bit each: unsigned carry (not-borrow for subtract) and signed overflow.
- REQ-011 The block SHALL have ports add_a and add_b, output, 32 bits each, and add_cin, output, 1 bit: these drive the shared 32-bit carry-lookahead adder.
- REQ-012 The block SHALL have ports add_sum, input, 32 bits, and add_cout, input, 1 bit: the adder result.

Function
- REQ-013 The block SHALL implement states IDLE, LO, HI and DONE.
- REQ-014 In IDLE or DONE, start=1 SHALL latch the following and move to LO: x, y_eff = op_sub ? ~y : y, and cin0 = op_sub.
- REQ-015 start SHALL be ignored in LO and HI.
- REQ-016 In LO, the block SHALL drive add_a=x[31:0], add_b=y_eff[31:0] and add_cin=cin0 for exactly SETTLE cycles.
- REQ-017 On the last LO cycle, the block SHALL capture add_sum into result[31:0] and add_cout into an internal chain carry, then go to HI.
- REQ-018 In HI, the block SHALL drive add_a=x[63:32], add_b=y_eff[63:32] and add_cin=chain carry for SETTLE cycles.
- REQ-019 On the last HI cycle, the block SHALL capture add_sum into result[63:32] and set carry_out=add_cout.
- REQ-020 On the same last HI cycle, the block SHALL set overflow=(x[63]==y_eff[63]) & (add_sum[31]!=x[63]), then go to DONE.
- REQ-021 In DONE, done=1 for exactly one cycle; the block SHALL then go to IDLE, or to LO if start=1.
- REQ-022 busy SHALL be 1 in LO and HI and 0 in IDLE and DONE.
- REQ-023 Latency: with start accepted at edge t, done SHALL be high in cycle t+2*SETTLE+1.
- REQ-024 Back-to-back operations SHALL have a period of 2*SETTLE+1 cycles.
- REQ-025 result, carry_out and overflow SHALL hold their values from done until the next completion.
- REQ-026 Partial result bits SHALL NOT be visible early: result[31:0] may update during HI, but the 64-bit result, carry_out and overflow are defined only from the done cycle on.
- REQ-027 In IDLE and DONE, add_a, add_b and add_cin SHALL be 0.
- REQ-028 A single SETTLE-wide down-counter SHALL be shared by LO and HI, reloaded on each state entry.

Reset
- REQ-029 With rst=1 at a rising edge, the block SHALL next cycle enter IDLE and clear: busy, done, result, carry_out, overflow, add_a, add_b, add_cin, chain carry and counter.
- REQ-030 rst SHALL take priority over start.
- REQ-031 rst asserted mid-operation SHALL abort the operation with no done pulse.

Verification
Bench model: add_sum/add_cout = add_a + add_b + add_cin, combinational; SETTLE=2.
- REQ-032 add 0x00000000_FFFFFFFF + 0x1 -> add_cin=1 during HI; result=0x00000001_00000000, carry_out=0, overflow=0; done 5 cycles after start edge.
- REQ-033 sub 0x5 - 0x7 -> result=0xFFFFFFFF_FFFFFFFE, carry_out=0, overflow=0.
- REQ-034 add 0x7FFFFFFF_FFFFFFFF + 0x1 -> result=0x80000000_00000000, overflow=1, carry_out=0.
- REQ-035 add 0xFFFFFFFF_FFFFFFFF + 0x1 -> result=0, carry_out=1, overflow=0.
- REQ-036 start pulsed in LO with new operands -> ignored; first result unchanged. Then rst=1 during HI of the next operation -> no done; all outputs 0 the following cycle.
- REQ-037 start held high continuously -> done every 5 cycles; each result matches the operands sampled at its start edge.
